// File: rtl/digital_clock_pkg.sv
// Shared definitions for the display scan logic: scan state encoding,
// default slot timing and the prescaler width helper.
package digital_clock_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_DRIVE = 2'd2
    } scan_state_e;

    localparam int DEF_PRESCALE = 1000;
    localparam int DEF_BLANK    = 2;

    // A single-cycle slot still needs a one-bit counter.
    function automatic int cnt_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-position counter: counts 0..PRESCALE-1 and wraps, or is held at
// zero while clr is asserted.
module scan_prescaler import digital_clock_pkg::*; #(
    parameter int PRESCALE = DEF_PRESCALE,
    localparam int CW = cnt_width(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_demux_n.sv
// Time-multiplexed active-low channel scanner: each slot blanks for BLANK
// cycles then drives one channel, auto-advancing or following a sampled select.
module scan_demux_n import digital_clock_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int SEL_W    = $clog2(NUM_CH),
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int BLANK    = DEF_BLANK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              auto,
    input  logic [SEL_W-1:0]  s,
    output logic [NUM_CH-1:0] out_n,
    output logic [SEL_W-1:0]  idx,
    output logic              slot_start
);

    localparam int CW = cnt_width(PRESCALE);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
    localparam logic [CW-1:0]    BLANK_END = CW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_e       state;
    scan_state_e       state_nxt;
    logic [SEL_W-1:0]  idx_nxt;
    logic              invalid;
    logic              invalid_nxt;
    logic              entry;
    logic              sel_ok;
    logic              clr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              wrap;
    logic [NUM_CH-1:0] out_d;
    logic              slot_d;

    // The counter is parked at zero in IDLE and on the edge that enters IDLE.
    assign clr     = !en || (state == SCAN_IDLE);
    assign cnt_nxt = (clr || wrap) ? '0 : cnt + 1'b1;
    assign sel_ok  = ({1'b0, s} <= {1'b0, LAST_CH});

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // State register; the outputs are flopped alongside it from next-state values
    // so they line up cycle-for-cycle with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCAN_IDLE;
            idx        <= '0;
            invalid    <= 1'b0;
            out_n      <= '1;
            slot_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            invalid    <= invalid_nxt;
            out_n      <= out_d;
            slot_start <= slot_d;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        invalid_nxt = invalid;
        entry       = 1'b0;
        if (!en) begin
            state_nxt = SCAN_IDLE;
        end else begin
            case (state)
                SCAN_IDLE:  entry = 1'b1;
                SCAN_BLANK: if (cnt == BLANK_END) state_nxt = SCAN_DRIVE;
                SCAN_DRIVE: if (wrap) entry = 1'b1;
                default:    state_nxt = SCAN_IDLE;
            endcase
        end
        // Slot entry is the only point where auto and s are sampled.
        if (entry) begin
            state_nxt = (BLANK > 0) ? SCAN_BLANK : SCAN_DRIVE;
            if (auto) begin
                invalid_nxt = 1'b0;
                if (state == SCAN_DRIVE) begin
                    idx_nxt = (idx == LAST_CH) ? '0 : idx + 1'b1;
                end
            end else if (sel_ok) begin
                invalid_nxt = 1'b0;
                idx_nxt     = s;
            end else begin
                invalid_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        out_d  = '1;
        slot_d = (state_nxt != SCAN_IDLE) && (cnt_nxt == '0);
        for (int i = 0; i < NUM_CH; i++) begin
            out_d[i] = !((state_nxt == SCAN_DRIVE) && !invalid_nxt &&
                         (idx_nxt == SEL_W'(i)));
        end
    end

endmodule

// File: tb/tb_scan_demux_n.sv
// Directed bench for scan_demux_n: three instances (4ch/blank2, 5ch/blank2,
// 4ch/blank0) share control inputs and are checked against hand-derived values.
module tb_scan_demux_n;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       auto  = 1'b0;
    logic [1:0] s_a   = 2'd0;
    logic [2:0] s_b   = 3'd0;

    logic [3:0] out_a, out_c;
    logic [4:0] out_b;
    logic [1:0] idx_a, idx_c;
    logic [2:0] idx_b;
    logic       slot_a, slot_b, slot_c;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    logic [3:0] e4;
    logic [4:0] e5;
    int c, ch4, ch5;

    always #5 clk = ~clk;

    scan_demux_n #(.NUM_CH(4), .PRESCALE(8), .BLANK(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .s(s_a),
        .out_n(out_a), .idx(idx_a), .slot_start(slot_a)
    );

    scan_demux_n #(.NUM_CH(5), .PRESCALE(8), .BLANK(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .s(s_b),
        .out_n(out_b), .idx(idx_b), .slot_start(slot_b)
    );

    scan_demux_n #(.NUM_CH(4), .PRESCALE(8), .BLANK(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .s(s_a),
        .out_n(out_c), .idx(idx_c), .slot_start(slot_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_out_a", out_a, 4'hF);
        check("rst_idx_a", idx_a, 0);
        check("rst_slot_a", slot_a, 0);
        rst_n = 1'b1;
        tick();
        check("idle_out_a", out_a, 4'hF);
        check("idle_slot_a", slot_a, 0);

        // Auto scan over five slots
        for (int k = 0; k < 40; k++) begin
            c   = k % 8;
            ch4 = (k / 8) % 4;
            e4  = 4'(1 << ch4);
            e4  = ~e4;
            exp_q.push_back((c < 2) ? 4'hF : e4);
        end
        en   = 1'b1;
        auto = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            c   = k % 8;
            ch4 = (k / 8) % 4;
            ch5 = (k / 8) % 5;
            check("auto_out_a", out_a, exp_q.pop_front());
            check("auto_idx_a", idx_a, ch4);
            check("auto_slot_a", slot_a, (c == 0) ? 1 : 0);
            e5 = 5'(1 << ch5);
            e5 = ~e5;
            if (c < 2) e5 = 5'h1F;
            check("auto5_out_b", out_b, e5);
            check("auto5_idx_b", idx_b, ch5);
            e4 = 4'(1 << ch4);
            e4 = ~e4;
            check("blank0_out_c", out_c, e4);
            check("blank0_slot_c", slot_c, (c == 0) ? 1 : 0);
        end

        // Async reset in the middle of DRIVE
        tick(4);
        check("pre_rst_out_a", out_a, 4'hD);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("async_rst_out_a", out_a, 4'hF);
        check("async_rst_idx_a", idx_a, 0);
        check("async_rst_slot_a", slot_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Drop enable at channel 2 mid-DRIVE, then resume
        en = 1'b1;
        tick(20);
        check("pre_drop_out_a", out_a, 4'hB);
        check("pre_drop_idx_a", idx_a, 2);
        en = 1'b0;
        tick();
        check("drop_out_a", out_a, 4'hF);
        check("drop_idx_a", idx_a, 2);
        check("drop_slot_a", slot_a, 0);
        check("drop_out_c", out_c, 4'hF);
        tick();
        check("idle_hold_out_a", out_a, 4'hF);
        en = 1'b1;
        tick();
        check("resume_slot_a", slot_a, 1);
        check("resume_out_a", out_a, 4'hF);
        check("resume_idx_a", idx_a, 2);
        check("resume_out_c", out_c, 4'hB);
        check("resume_slot_c", slot_c, 1);
        tick();
        check("resume_blank1_a", out_a, 4'hF);
        tick();
        check("resume_drive_a", out_a, 4'hB);
        check("resume_drive_slot_a", slot_a, 0);

        // Manual select: valid s=2 on dut_a, out-of-range s=6 on dut_b
        en    = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        auto  = 1'b0;
        s_a   = 2'd2;
        s_b   = 3'd6;
        en    = 1'b1;
        tick();
        check("man_slot_a", slot_a, 1);
        check("man_out_a", out_a, 4'hF);
        check("man_idx_a", idx_a, 2);
        for (int k = 1; k < 8; k++) begin
            if (k == 4) s_a = 2'd1;
            check("inval_out_b", out_b, 5'h1F);
            check("inval_idx_b", idx_b, 0);
            tick();
            if (k >= 2) begin
                check("man_drive_out_a", out_a, 4'hB);
                check("man_drive_idx_a", idx_a, 2);
            end
        end
        check("inval_last_out_b", out_b, 5'h1F);
        tick();
        check("man_next_slot_a", slot_a, 1);
        check("man_next_idx_a", idx_a, 1);
        check("man_next_blank_a", out_a, 4'hF);
        check("inval_next_out_b", out_b, 5'h1F);
        check("inval_next_slot_b", slot_b, 1);
        tick(2);
        check("man_next_drive_a", out_a, 4'hD);
        check("inval_drive_out_b", out_b, 5'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
